// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_pkg
// Purpose  : Shared definitions for the machine-mode trap controller:
//            sequencer state encoding, CSR addresses, mstatus/mie bit
//            positions and interrupt cause codes.
// Revision : 1.0 - initial release
// ============================================================================
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_R_MSTATUS = 3'd4,
        ST_REDIRECT  = 3'd5
    } trap_state_e;

    // CSR addresses
    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mie     = 12'h304;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;
    localparam logic [11:0] c_csr_mip     = 12'h344;

    // mstatus bit positions
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    // mie enable bit positions
    localparam int c_mie_msie = 3;
    localparam int c_mie_mtie = 7;
    localparam int c_mie_meie = 11;

    // Interrupt cause codes
    localparam logic [4:0] c_cause_msi = 5'd3;
    localparam logic [4:0] c_cause_mti = 5'd7;
    localparam logic [4:0] c_cause_mei = 5'd11;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : trap_prio_enc
// Purpose  : Combinational interrupt priority encoder (MEI > MSI > MTI).
// Ports    : irq_i      - level interrupt lines [0]=MEI [1]=MSI [2]=MTI
//            mie_i      - mie CSR value
//            mie_glob_i - mstatus.MIE
//            pending_o  - an enabled interrupt is pending
//            cause_o    - cause code of the highest-priority one
// Revision : 1.0 - initial release
// ============================================================================
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    irq_i,
    input  logic [DW-1:0] mie_i,
    input  logic          mie_glob_i,
    output logic          pending_o,
    output logic [4:0]    cause_o
);

    always_comb begin
        pending_o = 1'b0;
        cause_o   = 5'd0;
        if (mie_glob_i) begin
            if (irq_i[0] && mie_i[c_mie_meie]) begin
                pending_o = 1'b1;
                cause_o   = c_cause_mei;
            end else if (irq_i[1] && mie_i[c_mie_msie]) begin
                pending_o = 1'b1;
                cause_o   = c_cause_msi;
            end else if (irq_i[2] && mie_i[c_mie_mtie]) begin
                pending_o = 1'b1;
                cause_o   = c_cause_mti;
            end
        end
    end

    // Only three enable bits matter here.
    logic w_unused_mie;
    assign w_unused_mie = ^{mie_i[DW-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

endmodule : trap_prio_enc
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode interrupt entry / mret return sequencer. Owns the
//            single CSR write port, arbitrating between pipeline CSR writes
//            and its own mepc/mcause/mstatus writes, and issues the pipeline
//            flush and the one-cycle PC redirect.
// Ports    : irq_i, mstatus_i, mie_i, mtvec_i, mepc_i - interrupt/CSR state
//            pc_i, pc_valid_i, mret_i                - execute-stage info
//            pipe_csr_*_i / pipe_csr_stall_o         - pipeline write port
//            csr_we_o, csr_addr_o, csr_wdata_o       - CSR file write port
//            flush_o, redirect_o, redirect_pc_o      - fetch control
//            busy_o                                  - sequence in progress
// Config   : TRAP_CTRL_VECTORED_EN - enables vectored mtvec mode (2'b01).
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       irq_i,
    input  logic [DW-1:0]    mstatus_i,
    input  logic [DW-1:0]    mie_i,
    input  logic [DW-1:0]    mtvec_i,
    input  logic [DW-1:0]    mepc_i,
    input  logic [DW-1:0]    pc_i,
    input  logic             pc_valid_i,
    input  logic             mret_i,
    input  logic             pipe_csr_we_i,
    input  logic [ADDRW-1:0] pipe_csr_addr_i,
    input  logic [DW-1:0]    pipe_csr_wdata_i,
    output logic             pipe_csr_stall_o,
    output logic             csr_we_o,
    output logic [ADDRW-1:0] csr_addr_o,
    output logic [DW-1:0]    csr_wdata_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [DW-1:0]    redirect_pc_o,
    output logic             busy_o
);

    trap_state_e      state_q;
    logic [4:0]       cause_q;
    logic [DW-1:0]    target_q;
    logic [DW-1:0]    mstatus_q;
    logic [DW-1:0]    mepc_q;
    logic             seq_we_q;
    logic [ADDRW-1:0] seq_addr_q;
    logic [DW-1:0]    seq_wdata_q;
    logic             redirect_q;
    logic [DW-1:0]    redirect_pc_q;

    logic          w_pending;
    logic [4:0]    w_cause;
    logic [DW-1:0] w_handler;
    logic          w_idle;
    logic          w_take_irq;
    logic          w_take_mret;
    logic          w_pass;

    trap_prio_enc #(.DW(DW)) u_prio_enc (
        .irq_i      (irq_i),
        .mie_i      (mie_i),
        .mie_glob_i (mstatus_i[c_mstatus_mie]),
        .pending_o  (w_pending),
        .cause_o    (w_cause)
    );

    // Handler target, computed from the live mtvec and latched at take time.
    logic [DW-1:0] w_base;
    assign w_base = {mtvec_i[DW-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    logic [DW-1:0] w_vec_off;
    assign w_vec_off = {{(DW-7){1'b0}}, w_cause, 2'b00};
    assign w_handler = (mtvec_i[1:0] == 2'b01) ? (w_base + w_vec_off) : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec_i[1:0];
    assign w_handler     = w_base;
`endif

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [DW-1:0] f_entry_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r                                     = s;
        r[c_mstatus_mpie]                     = s[c_mstatus_mie];
        r[c_mstatus_mie]                      = 1'b0;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo]  = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
    function automatic logic [DW-1:0] f_ret_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r                                     = s;
        r[c_mstatus_mie]                      = s[c_mstatus_mpie];
        r[c_mstatus_mpie]                     = 1'b1;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo]  = 2'b11;
        return r;
    endfunction

    assign w_idle      = (state_q == ST_IDLE);
    assign w_take_mret = w_idle && pc_valid_i && mret_i;
    assign w_take_irq  = w_idle && pc_valid_i && !mret_i && w_pending;
    assign w_pass      = w_idle && !w_take_mret && !w_take_irq;

    // The sequencer's write for each state is prepared on the transition
    // into that state, so the CSR write port sees registered values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cause_q       <= 5'd0;
            target_q      <= '0;
            mstatus_q     <= '0;
            mepc_q        <= '0;
            seq_we_q      <= 1'b0;
            seq_addr_q    <= '0;
            seq_wdata_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            seq_we_q      <= 1'b0;
            seq_addr_q    <= '0;
            seq_wdata_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_take_mret || w_take_irq) begin
                        cause_q   <= w_cause;
                        target_q  <= w_handler;
                        mstatus_q <= mstatus_i;
                        mepc_q    <= mepc_i;
                        seq_we_q  <= 1'b1;
                    end
                    if (w_take_mret) begin
                        state_q     <= ST_R_MSTATUS;
                        seq_addr_q  <= ADDRW'(c_csr_mstatus);
                        seq_wdata_q <= f_ret_mstatus(mstatus_i);
                    end else if (w_take_irq) begin
                        state_q     <= ST_W_MEPC;
                        seq_addr_q  <= ADDRW'(c_csr_mepc);
                        seq_wdata_q <= pc_i;
                    end
                end
                ST_W_MEPC: begin
                    state_q     <= ST_W_MCAUSE;
                    seq_we_q    <= 1'b1;
                    seq_addr_q  <= ADDRW'(c_csr_mcause);
                    seq_wdata_q <= {1'b1, {(DW-6){1'b0}}, cause_q};
                end
                ST_W_MCAUSE: begin
                    state_q     <= ST_W_MSTATUS;
                    seq_we_q    <= 1'b1;
                    seq_addr_q  <= ADDRW'(c_csr_mstatus);
                    seq_wdata_q <= f_entry_mstatus(mstatus_q);
                end
                ST_W_MSTATUS: begin
                    state_q       <= ST_REDIRECT;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= target_q;
                end
                ST_R_MSTATUS: begin
                    state_q       <= ST_REDIRECT;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= mepc_q;
                end
                ST_REDIRECT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline writes only reach the CSR file in IDLE without a take; the
    // address/data are zeroed when no write is requested.
    assign csr_we_o         = w_pass ? pipe_csr_we_i : seq_we_q;
    assign csr_addr_o       = w_pass ? (pipe_csr_we_i ? pipe_csr_addr_i : '0) : seq_addr_q;
    assign csr_wdata_o      = w_pass ? (pipe_csr_we_i ? pipe_csr_wdata_i : '0) : seq_wdata_q;
    assign pipe_csr_stall_o = w_pass ? 1'b0 : pipe_csr_we_i;
    assign flush_o          = !w_idle || w_take_irq || w_take_mret;
    assign busy_o           = !w_idle;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Self-checking bench for trap_ctrl: combinational take/arbitration
//            vectors plus hand-written interrupt, mret and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic [2:0]  irq_i;
    logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i, pc_i;
    logic        pc_valid_i, mret_i;
    logic        pipe_csr_we_i;
    logic [11:0] pipe_csr_addr_i;
    logic [31:0] pipe_csr_wdata_i;
    logic        pipe_csr_stall_o;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        flush_o, redirect_o, busy_o;
    logic [31:0] redirect_pc_o;

    int n_cmp;
    int n_err;

    trap_ctrl #(.DW(32), .ADDRW(12)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .irq_i            (irq_i),
        .mstatus_i        (mstatus_i),
        .mie_i            (mie_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .pc_i             (pc_i),
        .pc_valid_i       (pc_valid_i),
        .mret_i           (mret_i),
        .pipe_csr_we_i    (pipe_csr_we_i),
        .pipe_csr_addr_i  (pipe_csr_addr_i),
        .pipe_csr_wdata_i (pipe_csr_wdata_i),
        .pipe_csr_stall_o (pipe_csr_stall_o),
        .csr_we_o         (csr_we_o),
        .csr_addr_o       (csr_addr_o),
        .csr_wdata_o      (csr_wdata_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed vector: we, addr, wdata, flush, redirect, redirect_pc, busy, stall
    logic [80:0] w_obs;
    assign w_obs = {csr_we_o, csr_addr_o, csr_wdata_o, flush_o, redirect_o,
                    redirect_pc_o, busy_o, pipe_csr_stall_o};

    function automatic logic [80:0] mk(input logic we, input logic [11:0] a,
                                       input logic [31:0] d, input logic fl,
                                       input logic rd, input logic [31:0] rpc,
                                       input logic bz, input logic st);
        return {we, a, d, fl, rd, rpc, bz, st};
    endfunction

    task automatic chk(input string name, input logic [80:0] exp);
        n_cmp++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL %s: got we=%0b a=%h d=%h fl=%0b rd=%0b rpc=%h bz=%0b st=%0b, want we=%0b a=%h d=%h fl=%0b rd=%0b rpc=%h bz=%0b st=%0b",
                     name, w_obs[80], w_obs[79:68], w_obs[67:36], w_obs[35], w_obs[34],
                     w_obs[33:2], w_obs[1], w_obs[0],
                     exp[80], exp[79:68], exp[67:36], exp[35], exp[34],
                     exp[33:2], exp[1], exp[0]);
        end
    endtask

    task automatic idle_inputs();
        irq_i = 3'b000; mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
        pc_i = '0; pc_valid_i = 1'b0; mret_i = 1'b0;
        pipe_csr_we_i = 1'b0; pipe_csr_addr_i = '0; pipe_csr_wdata_i = '0;
    endtask

    // CSR inputs are scrambled after the take to show they were latched.
    task automatic scramble();
        irq_i = 3'b000; pc_valid_i = 1'b0; mret_i = 1'b0;
        mstatus_i = 32'hFFFF_FFFF; mie_i = 32'hFFFF_FFFF;
        mtvec_i = 32'hFFFF_FF01; mepc_i = 32'hDEAD_BEEF; pc_i = 32'hFFFF_FFF0;
    endtask

    task automatic irq_seq(input string nm, input logic [2:0] irq,
                           input logic [31:0] ms, input logic [31:0] mie,
                           input logic [31:0] mtvec, input logic [31:0] pc,
                           input logic [31:0] exp_cause, input logic [31:0] exp_ms,
                           input logic [31:0] exp_tgt, input logic pw);
        @(posedge clk_i); #1;
        irq_i = irq; mstatus_i = ms; mie_i = mie; mtvec_i = mtvec; pc_i = pc;
        mepc_i = '0; pc_valid_i = 1'b1; mret_i = 1'b0;
        #1 chk({nm, " take"}, mk(0, 12'h0, 32'h0, 1, 0, 32'h0, 0, 0));
        @(posedge clk_i); #1; scramble();
        #1 chk({nm, " mepc"}, mk(1, 12'h341, pc, 1, 0, 32'h0, 1, 0));
        @(posedge clk_i); #1;
        if (pw) begin
            pipe_csr_we_i = 1'b1; pipe_csr_addr_i = 12'h305; pipe_csr_wdata_i = 32'h200;
        end
        #1 chk({nm, " mcause"}, mk(1, 12'h342, exp_cause, 1, 0, 32'h0, 1, pw));
        @(posedge clk_i); #2;
        chk({nm, " mstatus"}, mk(1, 12'h300, exp_ms, 1, 0, 32'h0, 1, pw));
        @(posedge clk_i); #2;
        chk({nm, " redirect"}, mk(0, 12'h0, 32'h0, 1, 1, exp_tgt, 1, pw));
        @(posedge clk_i); #2;
        chk({nm, " idle"}, mk(pw, pw ? 12'h305 : 12'h0, pw ? 32'h200 : 32'h0,
                               0, 0, 32'h0, 0, 0));
        idle_inputs();
    endtask

    task automatic mret_seq(input string nm, input logic [2:0] irq,
                            input logic [31:0] ms, input logic [31:0] mie,
                            input logic [31:0] mepc, input logic [31:0] exp_ms);
        @(posedge clk_i); #1;
        irq_i = irq; mstatus_i = ms; mie_i = mie; mepc_i = mepc; mtvec_i = 32'h100;
        pc_i = 32'h50; pc_valid_i = 1'b1; mret_i = 1'b1;
        #1 chk({nm, " take"}, mk(0, 12'h0, 32'h0, 1, 0, 32'h0, 0, 0));
        @(posedge clk_i); #1; scramble();
        #1 chk({nm, " mstatus"}, mk(1, 12'h300, exp_ms, 1, 0, 32'h0, 1, 0));
        @(posedge clk_i); #2;
        chk({nm, " redirect"}, mk(0, 12'h0, 32'h0, 1, 1, mepc, 1, 0));
        @(posedge clk_i); #2;
        chk({nm, " idle"}, mk(0, 12'h0, 32'h0, 0, 0, 32'h0, 0, 0));
        idle_inputs();
    endtask

    typedef struct {
        string       name;
        logic [2:0]  irq;
        logic [31:0] ms;
        logic [31:0] mie;
        logic        pcv;
        logic        mret;
        logic        pwe;
        logic        ex_we;
        logic [11:0] ex_a;
        logic [31:0] ex_d;
        logic        ex_fl;
        logic        ex_st;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] exp_vec_tgt;
        n_cmp = 0;
        n_err = 0;

        // Single-cycle IDLE vectors: pipeline writes are 0x305 <= 0x200.
        vecs[0] = '{"quiet",        3'b000, 32'h0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h000, 1'b0, 1'b0};
        vecs[1] = '{"pass_write",   3'b000, 32'h0, 32'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305, 32'h200, 1'b0, 1'b0};
        vecs[2] = '{"gmie_off",     3'b001, 32'h0, 32'h800, 1'b1, 1'b0, 1'b1, 1'b1, 12'h305, 32'h200, 1'b0, 1'b0};
        vecs[3] = '{"take_drop",    3'b001, 32'h8, 32'h800, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 32'h000, 1'b1, 1'b1};
        vecs[4] = '{"no_pcvalid",   3'b001, 32'h8, 32'h800, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305, 32'h200, 1'b0, 1'b0};
        vecs[5] = '{"mret_take",    3'b000, 32'h0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 32'h000, 1'b1, 1'b1};
        vecs[6] = '{"mret_nopcv",   3'b000, 32'h0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 12'h305, 32'h200, 1'b0, 1'b0};
        vecs[7] = '{"mie_mismatch", 3'b100, 32'h8, 32'h800, 1'b1, 1'b0, 1'b1, 1'b1, 12'h305, 32'h200, 1'b0, 1'b0};
        vecs[8] = '{"mti_take",     3'b100, 32'h8, 32'h080, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h000, 1'b1, 1'b0};
        vecs[9] = '{"msi_take",     3'b010, 32'h8, 32'h008, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 32'h000, 1'b1, 1'b1};

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 chk("reset_state", mk(0, 12'h0, 32'h0, 0, 0, 32'h0, 0, 0));
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            irq_i = vecs[i].irq; mstatus_i = vecs[i].ms; mie_i = vecs[i].mie;
            pc_valid_i = vecs[i].pcv; mret_i = vecs[i].mret;
            pipe_csr_we_i = vecs[i].pwe; pipe_csr_addr_i = 12'h305; pipe_csr_wdata_i = 32'h200;
            #1 chk(vecs[i].name, mk(vecs[i].ex_we, vecs[i].ex_a, vecs[i].ex_d,
                                    vecs[i].ex_fl, 0, 32'h0, 0, vecs[i].ex_st));
            // Withdraw before the edge so the state stays IDLE.
            idle_inputs();
        end

        // MEI entry with a pipeline write held off during W_MCAUSE.
        irq_seq("mei", 3'b001, 32'h8, 32'h800, 32'h100, 32'h40,
                32'h8000_000B, 32'h0000_1880, 32'h100, 1'b1);
        // All pending, all enabled: MEI wins.
        irq_seq("prio_all", 3'b111, 32'h8, 32'h888, 32'h100, 32'h80,
                32'h8000_000B, 32'h0000_1880, 32'h100, 1'b0);
        // MEI disabled: MSI wins; snapshot keeps unrelated bits.
        irq_seq("prio_msi", 3'b111, 32'hA000_000A, 32'h088, 32'h200, 32'h84,
                32'h8000_0003, 32'hA000_1882, 32'h200, 1'b0);
        // MTI with mtvec mode 01.
`ifdef TRAP_CTRL_VECTORED_EN
        exp_vec_tgt = 32'h11C;
`else
        exp_vec_tgt = 32'h100;
`endif
        irq_seq("mti_vec", 3'b100, 32'h8, 32'h080, 32'h101, 32'h90,
                32'h8000_0007, 32'h0000_1880, exp_vec_tgt, 1'b0);
        // Mode 11 is always direct.
        irq_seq("mti_mode3", 3'b100, 32'h8, 32'h080, 32'h103, 32'h94,
                32'h8000_0007, 32'h0000_1880, 32'h100, 1'b0);

        mret_seq("mret", 3'b000, 32'h1880, 32'h000, 32'h44, 32'h0000_1888);
        // mret beats an enabled interrupt in the same cycle.
        mret_seq("mret_vs_irq", 3'b001, 32'h0088, 32'h800, 32'h48, 32'h0000_1888);

        // Reset during W_MCAUSE aborts the sequence.
        @(posedge clk_i); #1;
        irq_i = 3'b001; mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h100;
        pc_i = 32'h60; pc_valid_i = 1'b1;
        @(posedge clk_i); #1; scramble();
        @(posedge clk_i); #2;
        chk("rst_pre_mcause", mk(1, 12'h342, 32'h8000_000B, 1, 0, 32'h0, 1, 0));
        idle_inputs();
        rst_ni = 1'b0;
        #1 chk("rst_async", mk(0, 12'h0, 32'h0, 0, 0, 32'h0, 0, 0));
        @(posedge clk_i); #2;
        chk("rst_held", mk(0, 12'h0, 32'h0, 0, 0, 32'h0, 0, 0));
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #2;
            chk($sformatf("rst_after_%0d", k), mk(0, 12'h0, 32'h0, 0, 0, 32'h0, 0, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire
